// File: rtl/dbg_pkg.sv
// Shared constants for the uart debug command engine: frame opcodes, reply bytes
// and the FSM state encoding.
package dbg_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_BAD  = 8'h3F;  // '?'

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_GET_ADDR = 3'd1;
  localparam state_t S_GET_DATA = 3'd2;
  localparam state_t S_EXEC     = 3'd3;
  localparam state_t S_RD_WAIT  = 3'd4;
  localparam state_t S_TX_START = 3'd5;
  localparam state_t S_TX_WAIT  = 3'd6;

  function automatic logic is_known_op(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/uart_cmd_engine.sv
// Debug command engine: assembles uart bytes into W/R frames, runs one register
// bus access per frame and answers every completed frame with one uart byte.
module uart_cmd_engine
  import dbg_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 120000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              received,
  input  logic [7:0]        rx_byte,
  input  logic              recv_error,
  input  logic              is_transmitting,
  output logic              transmit,
  output logic [7:0]        tx_byte,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // Handshake: received/recv_error and transmit/reg_we/reg_re are single-cycle
  // strobes with no back-pressure; is_transmitting is the only flow control and
  // transmit fires only in a cycle where it is low.

  state_t            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [1:0]        hold_q, hold_d;
  logic              overrun_q, overrun_d;
  logic              tmo_err_q, tmo_err_d;

  logic rx_ok;
  logic in_frame;
  logic tmo_hit;
  logic busy_state;

  assign rx_ok      = received & ~recv_error;
  assign in_frame   = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);
  assign tmo_hit    = in_frame && (tmo_q == TW'(TIMEOUT_CYC));
  assign busy_state = (state_q == S_EXEC) || (state_q == S_RD_WAIT) ||
                      (state_q == S_TX_START) || (state_q == S_TX_WAIT);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_byte_d = tx_byte_q;
    hold_d    = hold_q;
    overrun_d = overrun_q | (rx_ok & busy_state);
    tmo_err_d = tmo_err_q;
    tmo_d     = (received || !in_frame || tmo_hit) ? '0 : tmo_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        if (rx_ok) begin
          op_d = rx_byte;
          if (is_known_op(rx_byte)) begin
            state_d = S_GET_ADDR;
          end else begin
            tx_byte_d = RSP_BAD;
            state_d   = S_TX_START;
          end
        end
      end
      S_GET_ADDR, S_GET_DATA: begin
        // A byte landing on the timeout cycle still counts as arriving in time.
        if (recv_error) begin
          state_d = S_IDLE;
        end else if (received) begin
          if (state_q == S_GET_ADDR) begin
            addr_d  = rx_byte[ADDR_W-1:0];
            state_d = (op_q == OP_WRITE) ? S_GET_DATA : S_EXEC;
          end else begin
            wdata_d = rx_byte;
            state_d = S_EXEC;
          end
        end else if (tmo_hit) begin
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_EXEC: begin
        if (op_q == OP_WRITE) begin
          tx_byte_d = RSP_OK;
          state_d   = S_TX_START;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        tx_byte_d = reg_rdata;
        state_d   = S_TX_START;
      end
      S_TX_START: begin
        if (!is_transmitting) begin
          hold_d  = 2'd2;
          state_d = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        // The uart raises is_transmitting a little after the strobe, so its
        // low level is not trusted for the first two cycles.
        if (hold_q != 2'd0) begin
          hold_d = hold_q - 2'd1;
        end else if (!is_transmitting) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      tx_byte_q <= '0;
      tmo_q     <= '0;
      hold_q    <= '0;
      overrun_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tx_byte_q <= tx_byte_d;
      tmo_q     <= tmo_d;
      hold_q    <= hold_d;
      overrun_q <= overrun_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign transmit    = (state_q == S_TX_START) && !is_transmitting;
  assign tx_byte     = tx_byte_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_we      = (state_q == S_EXEC) && (op_q == OP_WRITE);
  assign reg_re      = (state_q == S_EXEC) && (op_q != OP_WRITE);
  assign overrun     = overrun_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Bench for uart_cmd_engine: uart strobe driver, uart busy model, 16x8 register
// file with one-cycle read latency, and a frame-level reference model.
module tb_uart_cmd_engine;

  localparam int T = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       received = 1'b0;
  logic       recv_error = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       is_transmitting;
  logic       transmit;
  logic [7:0] tx_byte;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       overrun;
  logic       timeout_err;

  logic       force_busy = 1'b0;
  int         busy_cnt = 0;
  int         cyc = 0;
  int         rx_cyc = 0;
  int         last_we_cyc = -1;
  int         last_re_cyc = -1;
  int         last_tx_cyc = -1;
  int         n_we = 0;
  int         n_re = 0;
  int         n_tx = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  logic [7:0]  model_mem [16];
  logic [7:0]  exp_tx_q[$];
  logic [11:0] exp_wr_q[$];
  logic [3:0]  exp_rd_q[$];

  logic [7:0] rf [16];
  logic       rf_ready = 1'b0;
  logic [7:0] tx_held = 8'h00;
  logic       tx_track = 1'b0;

  uart_cmd_engine #(.ADDR_W(4), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
    .recv_error(recv_error), .is_transmitting(is_transmitting),
    .transmit(transmit), .tx_byte(tx_byte), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .overrun(overrun), .timeout_err(timeout_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #800000;
    $display("FAIL watchdog: sim time %0t reached, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- uart tx and register file models ----------------
  assign is_transmitting = force_busy | (busy_cnt != 0);

  always @(posedge clk) begin
    if (transmit) busy_cnt <= 8;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  always @(posedge clk) begin
    if (!rf_ready) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
      rf_ready <= 1'b1;
    end else if (reg_we) begin
      rf[reg_addr] <= reg_wdata;
    end
    reg_rdata <= reg_re ? rf[reg_addr] : 8'($urandom);
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reg_we || reg_re) check_eq("we_re_exclusive", reg_we & reg_re, 0);
    if (reg_we) begin
      n_we++;
      last_we_cyc = cyc;
      check_eq("write_expected", exp_wr_q.size() != 0, 1);
      if (exp_wr_q.size() != 0) check_eq("write_addr_data", {reg_addr, reg_wdata}, exp_wr_q.pop_front());
    end
    if (reg_re) begin
      n_re++;
      last_re_cyc = cyc;
      check_eq("read_expected", exp_rd_q.size() != 0, 1);
      if (exp_rd_q.size() != 0) check_eq("read_addr", reg_addr, exp_rd_q.pop_front());
    end
    if (transmit) begin
      n_tx++;
      last_tx_cyc = cyc;
      check_eq("tx_expected", exp_tx_q.size() != 0, 1);
      if (exp_tx_q.size() != 0) check_eq("tx_byte", tx_byte, exp_tx_q.pop_front());
      tx_held  = tx_byte;
      tx_track = 1'b1;
    end else if (tx_track) begin
      if (busy_cnt != 0) check_eq("tx_byte_hold", tx_byte, tx_held);
      else tx_track = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    rx_byte  = b;
    received = 1'b1;
    rx_cyc   = cyc;
    @(posedge clk); #1;
    received = 1'b0;
    rx_byte  = 8'($urandom);
  endtask

  task automatic pulse_err(input logic with_byte);
    @(posedge clk); #1;
    recv_error = 1'b1;
    received   = with_byte;
    rx_byte    = 8'h41;
    @(posedge clk); #1;
    recv_error = 1'b0;
    received   = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data, input int gap);
    model_mem[addr[3:0]] = data;
    exp_wr_q.push_back({addr[3:0], data});
    exp_tx_q.push_back(8'h4B);
    send_byte(8'h57, gap);
    send_byte(addr, gap);
    send_byte(data, gap);
  endtask

  task automatic do_read(input logic [7:0] addr, input int gap);
    exp_rd_q.push_back(addr[3:0]);
    exp_tx_q.push_back(model_mem[addr[3:0]]);
    send_byte(8'h52, gap);
    send_byte(addr, gap);
  endtask

  task automatic do_bad(input logic [7:0] op, input int gap);
    exp_tx_q.push_back(8'h3F);
    send_byte(op, gap);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_tx_q.size() != 0 || is_transmitting) && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("drain_in_time", k < 500, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_transmit"}, transmit, 0);
    check_eq({tag, "_tx_byte"}, tx_byte, 0);
    check_eq({tag, "_reg_addr"}, reg_addr, 0);
    check_eq({tag, "_reg_wdata"}, reg_wdata, 0);
    check_eq({tag, "_reg_we"}, reg_we, 0);
    check_eq({tag, "_reg_re"}, reg_re, 0);
    check_eq({tag, "_overrun"}, overrun, 0);
    check_eq({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int we0, re0, tx0, rel_cyc, kind, gap;
    logic [7:0] op;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: write, upper address bits ignored, latencies
    do_write(8'hF5, 8'hA5, 0);
    wait_idle();
    check_eq("t1_we_latency", last_we_cyc, rx_cyc + 1);
    check_eq("t1_tx_latency", last_tx_cyc, rx_cyc + 2);
    check_eq("t1_we_count", n_we, 1);

    // 2: read back
    do_read(8'h05, 0);
    wait_idle();
    check_eq("t2_re_latency", last_re_cyc, rx_cyc + 1);
    check_eq("t2_tx_latency", last_tx_cyc, rx_cyc + 3);

    // 3: unknown opcode
    we0 = n_we; re0 = n_re;
    do_bad(8'h41, 0);
    wait_idle();
    check_eq("t3_no_write", n_we, we0);
    check_eq("t3_no_read", n_re, re0);
    do_read(8'h05, 2);
    wait_idle();

    // 4: inter-byte timeout
    tx0 = n_tx; we0 = n_we;
    send_byte(8'h57, 0);
    repeat (T) @(posedge clk);
    @(negedge clk);
    check_eq("t4_no_timeout_yet", timeout_err, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("t4_timeout_err", timeout_err, 1);
    repeat (5) @(posedge clk);
    #1;
    check_eq("t4_no_tx", n_tx, tx0);
    check_eq("t4_no_write", n_we, we0);
    do_read(8'h05, 1);
    wait_idle();

    // 5: tx back-pressure and overrun
    force_busy = 1'b1;
    tx0 = n_tx;
    do_write(8'h03, 8'hC3, 1);
    send_byte(8'h99, 3);
    repeat (45) @(posedge clk);
    #1;
    check_eq("t5_tx_held_off", n_tx, tx0);
    check_eq("t5_overrun", overrun, 1);
    @(posedge clk); #1;
    force_busy = 1'b0;
    rel_cyc = cyc;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_tx_on_release", last_tx_cyc, rel_cyc);
    wait_idle();

    // 6: framing error drops frame; reset mid-frame
    tx0 = n_tx; we0 = n_we;
    send_byte(8'h57, 0);
    send_byte(8'h05, 0);
    pulse_err(1'b0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("t6_err_no_write", n_we, we0);
    check_eq("t6_err_no_tx", n_tx, tx0);
    check_eq("t6_overrun_sticky", overrun, 1);
    send_byte(8'h57, 0);
    send_byte(8'h05, 0);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    do_write(8'h01, 8'h11, 0);
    wait_idle();
    do_read(8'h01, 0);
    wait_idle();

    // random frames, with framing-error noise while idle
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 20);
      if ($urandom_range(0, 3) == 0) begin
        pulse_err($urandom_range(0, 1) == 1);
        repeat (2) @(posedge clk);
        #1;
      end
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        do_write(8'($urandom), 8'($urandom), gap);
      end else if (kind == 2) begin
        do_read(8'($urandom), gap);
      end else begin
        op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
        do_bad(op, gap);
      end
      wait_idle();
    end

    check_eq("final_tx_queue_empty", exp_tx_q.size(), 0);
    check_eq("final_wr_queue_empty", exp_wr_q.size(), 0);
    check_eq("final_rd_queue_empty", exp_rd_q.size(), 0);
    check_eq("final_overrun", overrun, 0);
    check_eq("final_timeout_err", timeout_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
